// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback steps and drives the datapath mux/enable controls.
module mips_multicycle_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               pc_en,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      r_state;
  state_t      w_next;
  logic        w_iord;
  logic        w_memwrite;
  logic        w_irwrite;
  logic        w_regdst;
  logic        w_memtoreg;
  logic        w_regwrite;
  logic        w_alusrca;
  logic [1:0]  w_alusrcb;
  logic [1:0]  w_aluop;
  logic [1:0]  w_pcsrc;
  logic        w_pcwrite;
  logic        w_branch;
  logic        w_illegal;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluop    = 2'b00;
    w_pcsrc    = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // Operand B = SignImm<<2 so ALUOut holds the branch target for BRANCH
        w_alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset masks every output combinationally, including the debug state view
  always_comb begin
    iord       = ~reset & w_iord;
    memwrite   = ~reset & w_memwrite;
    irwrite    = ~reset & w_irwrite;
    regdst     = ~reset & w_regdst;
    memtoreg   = ~reset & w_memtoreg;
    regwrite   = ~reset & w_regwrite;
    alusrca    = ~reset & w_alusrca;
    alusrcb    = reset ? 2'b00 : w_alusrcb;
    aluop      = reset ? 2'b00 : w_aluop;
    pcsrc      = reset ? 2'b00 : w_pcsrc;
    pc_en      = ~reset & (w_pcwrite | (w_branch & zero));
    illegal_op = ~reset & w_illegal;
    state      = reset ? '0 : STATE_W'(r_state);
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction table, reset corner
// sequences and random instruction streams against a per-instruction trace model.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pc_en, illegal_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pc_en(pc_en),
    .illegal_op(illegal_op), .state(state)
  );

  logic [14:0] act_ctrl;
  assign act_ctrl = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                     alusrcb, aluop, pcsrc, pc_en, illegal_op};

  int n_tests = 0;
  int n_fail  = 0;
  int exp_trace[$];

  typedef struct {
    string        name;
    logic [5:0]   op;
    logic         zero;
    int unsigned  cycles;
    int unsigned  n_rw;
    int unsigned  n_mw;
    int unsigned  n_ir;
    int unsigned  n_pc;
    int unsigned  n_ill;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
  endfunction

  // Expected states visited by one instruction, starting at its FETCH
  task automatic build_trace(input logic [5:0] o);
    exp_trace.delete();
    exp_trace.push_back(0);
    exp_trace.push_back(1);
    case (o)
      6'b100011: begin exp_trace.push_back(2); exp_trace.push_back(3); exp_trace.push_back(4); end
      6'b101011: begin exp_trace.push_back(2); exp_trace.push_back(5); end
      6'b000000: begin exp_trace.push_back(6); exp_trace.push_back(7); end
      6'b000100: exp_trace.push_back(8);
      6'b001000: begin exp_trace.push_back(9); exp_trace.push_back(10); end
      6'b000010: exp_trace.push_back(11);
      default: ;
    endcase
  endtask

  // Per-state control table
  function automatic logic [14:0] exp_ctrl(input int s, input logic [5:0] o, input logic z);
    logic e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_pc, e_ill;
    logic [1:0] e_sb, e_aop, e_ps;
    {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_pc, e_ill} = '0;
    e_sb = 2'b00; e_aop = 2'b00; e_ps = 2'b00;
    case (s)
      0:  begin e_sb = 2'b01; e_ir = 1'b1; e_pc = 1'b1; end
      1:  begin e_sb = 2'b11; e_ill = ~is_legal(o); end
      2:  begin e_sa = 1'b1; e_sb = 2'b10; end
      3:  e_iord = 1'b1;
      4:  begin e_m2r = 1'b1; e_rw = 1'b1; end
      5:  begin e_iord = 1'b1; e_mw = 1'b1; end
      6:  begin e_sa = 1'b1; e_aop = 2'b10; end
      7:  begin e_rd = 1'b1; e_rw = 1'b1; end
      8:  begin e_sa = 1'b1; e_aop = 2'b01; e_ps = 2'b01; e_pc = z; end
      9:  begin e_sa = 1'b1; e_sb = 2'b10; end
      10: e_rw = 1'b1;
      11: begin e_ps = 2'b10; e_pc = 1'b1; end
      default: ;
    endcase
    return {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_sb, e_aop, e_ps, e_pc, e_ill};
  endfunction

  // Runs one instruction from FETCH; op/zero are scrambled in states that must ignore them
  task automatic run_instr(input logic [5:0] iop, input logic iz,
                           output int unsigned cyc, output int unsigned nrw,
                           output int unsigned nmw, output int unsigned nir,
                           output int unsigned npc, output int unsigned nill);
    int unsigned k;
    int es;
    build_trace(iop);
    k = 0; nrw = 0; nmw = 0; nir = 0; npc = 0; nill = 0;
    do begin
      es   = (k < exp_trace.size()) ? exp_trace[k] : 0;
      op   = (es == 1 || es == 2) ? iop : 6'($urandom);
      zero = (es == 8) ? iz : 1'($urandom);
      @(negedge clk);
      check("state", 32'(state), 32'(es));
      check("ctrl", 32'(act_ctrl), 32'(exp_ctrl(es, op, zero)));
      nrw += 32'(regwrite); nmw += 32'(memwrite); nir += 32'(irwrite);
      npc += 32'(pc_en);    nill += 32'(illegal_op);
      @(posedge clk); #1;
      k++;
    end while (state != 4'd0 && k < 20);
    if (state != 4'd0) check("return_to_fetch", 32'(state), 32'd0);
    cyc = k;
  endtask

  vec_t vecs[$];
  int unsigned c, rw, mw, ir, pc, il, total;
  logic [5:0] legal_ops[6];

  initial begin
    vecs.push_back('{"lw",    6'b100011, 1'b0, 5, 1, 0, 1, 1, 0});
    vecs.push_back('{"sw",    6'b101011, 1'b1, 4, 0, 1, 1, 1, 0});
    vecs.push_back('{"rtype", 6'b000000, 1'b0, 4, 1, 0, 1, 1, 0});
    vecs.push_back('{"beq_t", 6'b000100, 1'b1, 3, 0, 0, 1, 2, 0});
    vecs.push_back('{"beq_n", 6'b000100, 1'b0, 3, 0, 0, 1, 1, 0});
    vecs.push_back('{"addi",  6'b001000, 1'b0, 4, 1, 0, 1, 1, 0});
    vecs.push_back('{"j",     6'b000010, 1'b0, 3, 0, 0, 1, 2, 0});
    vecs.push_back('{"ill3f", 6'b111111, 1'b0, 2, 0, 0, 1, 1, 1});
    vecs.push_back('{"ill01", 6'b000001, 1'b1, 2, 0, 0, 1, 1, 1});
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    reset = 1'b1; op = '0; zero = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctrl", 32'(act_ctrl), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].zero, c, rw, mw, ir, pc, il);
      check({vecs[i].name, "_cycles"},   c,  vecs[i].cycles);
      check({vecs[i].name, "_regwrite"}, rw, vecs[i].n_rw);
      check({vecs[i].name, "_memwrite"}, mw, vecs[i].n_mw);
      check({vecs[i].name, "_irwrite"},  ir, vecs[i].n_ir);
      check({vecs[i].name, "_pc_en"},    pc, vecs[i].n_pc);
      check({vecs[i].name, "_illegal"},  il, vecs[i].n_ill);
    end

    total = 0;
    run_instr(6'b000000, 1'b0, c, rw, mw, ir, pc, il); total += c;
    run_instr(6'b001000, 1'b0, c, rw, mw, ir, pc, il); total += c;
    run_instr(6'b000010, 1'b0, c, rw, mw, ir, pc, il); total += c;
    check("b2b_total_cycles", total, 32'd11);

    // Reset held two cycles from EXECUTE
    op = 6'b000000; zero = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_execute", 32'(state), 32'd6);
    reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      check("rst_hold_state", 32'(state), 32'd0);
      check("rst_hold_ctrl", 32'(act_ctrl), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    run_instr(6'b000000, 1'b0, c, rw, mw, ir, pc, il);
    check("post_reset_cycles", c, 32'd4);

    // Illegal op, then reset during lw MEMRD must suppress its writeback
    run_instr(6'b111111, 1'b0, c, rw, mw, ir, pc, il);
    check("illegal_pulse", il, 32'd1);
    op = 6'b100011;
    repeat (3) @(posedge clk);
    #1;
    check("lw_in_memrd", 32'(state), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_memrd_regwrite", 32'(regwrite), 32'd0);
    check("rst_memrd_ctrl", 32'(act_ctrl), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_memrd_next", 32'(state), 32'd0);
    run_instr(6'b100011, 1'b0, c, rw, mw, ir, pc, il);
    check("lw_after_reset_regwrite", rw, 32'd1);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] rop;
      rop = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
      run_instr(rop, 1'($urandom), c, rw, mw, ir, pc, il);
      check("rand_cycles", c, exp_trace.size());
      check("rand_irwrite", ir, 32'd1);
      check("rand_wr_pulses", rw + mw, (exp_trace.size() >= 4) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences the shared ALU, register file, instruction register, unified memory and PC update across Fetch, Decode, Execute, Memory and Writeback states. It also drives the ALU operand muxes, including selecting the sign-extended immediate (and the sign-extended immediate shifted left by 2) as ALU operand B. It sits beside the ALU decoder, which consumes `aluop`.

Parameters:
- STATE_W, 4, width of state register and `state` debug port (must be ≥4)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  instr[31:26] from instruction register
- zero  in  1  ALU zero flag
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write enable
- irwrite  out  1  instruction register load
- regdst  out  1  write register select: 0 = rt, 1 = rd
- memtoreg  out  1  writeback data select: 0 = ALUOut, 1 = Data
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU operand A select: 0 = PC, 1 = A
- alusrcb  out  2  ALU operand B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- aluop  out  2  00 add, 01 sub, 10 funct-decoded
- pcsrc  out  2  PC source select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC register enable
- illegal_op  out  1  one-cycle pulse in DECODE on unsupported opcode
- state  out  STATE_W  current state (debug)

Behaviour:
- Moore FSM on rising `clk`; all outputs are a combinational decode of the registered state, except `pc_en` and `illegal_op`.
- `pc_en = pcwrite | (branch & zero)`; `pcwrite` and `branch` are internal.
- All control signals not listed for a state are 0.
- Reset:
  - `reset=1` at a clock edge forces state to FETCH (0), regardless of current state, including mid-instruction.
  - While `reset=1`, all outputs are forced to 0, overriding the state decode.
  - The first edge with `reset=0` performs the FETCH actions.
- State encodings, outputs and transitions:
  - FETCH(0): `alusrcb=01`, `irwrite=1`, `pcwrite=1` → DECODE
  - DECODE(1): `alusrcb=11` (branch target precompute) → next state by `op`:
    - 100011 (lw), 101011 (sw) → MEMADR
    - 000000 (R-type) → EXECUTE
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JUMP
    - other → FETCH, with `illegal_op=1` for this cycle
  - MEMADR(2): `alusrca=1`, `alusrcb=10` → MEMRD if op=lw, else MEMWR
  - MEMRD(3): `iord=1` → MEMWB
  - MEMWB(4): `memtoreg=1`, `regwrite=1` → FETCH
  - MEMWR(5): `iord=1`, `memwrite=1` → FETCH
  - EXECUTE(6): `alusrca=1`, `aluop=10` → ALUWB
  - ALUWB(7): `regdst=1`, `regwrite=1` → FETCH
  - BRANCH(8): `alusrca=1`, `aluop=01`, `pcsrc=01`, `branch=1` → FETCH
  - ADDIEX(9): `alusrca=1`, `alusrcb=10` → ADDIWB
  - ADDIWB(10): `regwrite=1` → FETCH
  - JUMP(11): `pcsrc=10`, `pcwrite=1` → FETCH
  - codes 12–15: unreachable; if entered, output all-zero controls and go to FETCH next cycle
- `op` is sampled only in DECODE and MEMADR; `op` changes in other states have no effect.
- `zero` matters only in BRANCH.
- Cycles per instruction, FETCH inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Each instruction produces exactly one `irwrite` pulse and at most one cycle of `regwrite`/`memwrite`.
- `pc_en` is high exactly in FETCH, in JUMP, and in BRANCH when `zero=1`.

Test Plan:
- Hold reset 2 cycles in state 6 → `state=0`, all outputs 0 during reset. Release → cycle 1 shows `irwrite=1`, `pc_en=1`, `alusrcb=01`.
- op=100011 → state trace 0,1,2,3,4,0. `iord=1` at state 3; `memtoreg=1` and `regwrite=1` at state 4; `alusrcb=10` at state 2.
- op=101011 → trace 0,1,2,5,0. `memwrite=1` only at state 5; `regwrite` never asserted.
- op=000100: with `zero=1` → `pc_en=1`, `pcsrc=01` at state 8. With `zero=0` → `pc_en=0` at state 8. Next state 0 in both cases.
- Back-to-back sequence op=000000, 001000, 000010 → traces 0,1,6,7 (`regdst=1`); 0,1,9,10 (`regdst=0`); 0,1,11 (`pcsrc=10`, `pc_en=1`). Total 11 cycles.
- op=111111 → `illegal_op=1` for 1 cycle in state 1, then state 0. Then assert reset in state 3 (lw mid-flight) → next state 0, no `regwrite` pulse.
